// File: rtl/enc_onehot2bin_buf_if.sv
// enc_onehot2bin_buf_if: upstream/downstream handshake and error-counter bundle for the encoder buffer
interface enc_onehot2bin_buf_if #(parameter int CNT_W = 8);
  logic             in_valid;
  logic [14:0]      in;
  logic             in_ready;
  logic             out_valid;
  logic [3:0]       out;
  logic             out_err;
  logic             out_ready;
  logic             err_clr;
  logic [CNT_W-1:0] err_cnt;
  modport master (output in_valid, in, out_ready, err_clr,
                  input  in_ready, out_valid, out, out_err, err_cnt);
  modport slave  (input  in_valid, in, out_ready, err_clr,
                  output in_ready, out_valid, out, out_err, err_cnt);
endinterface

// File: rtl/enc_onehot2bin_buf.sv
// enc_onehot2bin_buf: one-hot to binary encoder feeding a 2-entry FIFO with a saturating multi-hot counter
module enc_onehot2bin_buf #(parameter int CNT_W = 8) (
  input logic                 clk,
  input logic                 rst,
  enc_onehot2bin_buf_if.slave bus
);
  logic [4:0]       mem_q [2];
  logic             wr_q, rd_q;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       enc_val;
  logic             multi, push, pop;
  // Lowest set bit wins; an all-zero code keeps the 15 marker.
  always_comb begin
    enc_val = 4'hf;
    for (int i = 14; i >= 0; i--) if (bus.in[i]) enc_val = 4'(i);
  end
  assign multi     = |(bus.in & (bus.in - 15'd1));
  assign push      = bus.in_valid & bus.in_ready;
  assign pop       = bus.out_valid & bus.out_ready;
  assign occ_d     = occ_q + {1'b0, push} - {1'b0, pop};
  assign err_cnt_d = bus.err_clr ? '0 : (push & multi & ~&err_cnt_q) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      occ_q     <= 2'd0;
      err_cnt_q <= '0;
    end else begin
      if (push) mem_q[wr_q] <= {enc_val, multi};
      wr_q      <= wr_q ^ push;
      rd_q      <= rd_q ^ pop;
      occ_q     <= occ_d;
      err_cnt_q <= err_cnt_d;
    end
  assign bus.in_ready  = occ_q != 2'd2;
  assign bus.out_valid = occ_q != 2'd0;
  assign bus.out       = mem_q[rd_q][4:1];
  assign bus.out_err   = mem_q[rd_q][0];
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_enc_onehot2bin_buf.sv
// tb_enc_onehot2bin_buf: directed and random stimulus checked against a queue-based reference model
module tb_enc_onehot2bin_buf;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [4:0] q[$];
  int err_m = 0;
  enc_onehot2bin_buf_if #(.CNT_W(8)) bus();
  enc_onehot2bin_buf #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [4:0] ref_enc(input logic [14:0] v);
    int k;
    if (v == 0) return {4'd15, 1'b0};
    k = 0;
    while (!v[k]) k++;
    return {4'(k), $countones(v) > 1};
  endfunction
  task automatic check_state(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(q.size() < 2));
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk({tag, "_out"}, 32'(bus.out), 32'(q[0][4:1]));
      chk({tag, "_out_err"}, 32'(bus.out_err), 32'(q[0][0]));
    end
    chk({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'(err_m));
  endtask
  task automatic cyc(input string tag, input logic iv, input logic [14:0] d, input logic ordy, input logic clr);
    logic push, pop;
    logic [4:0] e;
    bus.in_valid = iv;
    bus.in = d;
    bus.out_ready = ordy;
    bus.err_clr = clr;
    push = iv && q.size() < 2;
    pop = ordy && q.size() > 0;
    e = ref_enc(d);
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(e);
    if (clr) err_m = 0;
    else if (push && e[0] && err_m < 255) err_m++;
    check_state(tag);
  endtask
  initial begin
    logic [14:0] d;
    bus.in_valid = 1'b0;
    bus.in = '0;
    bus.out_ready = 1'b0;
    bus.err_clr = 1'b0;
    #12;
    chk("reset_in_ready", 32'(bus.in_ready), 1);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_out", 32'(bus.out), 0);
    chk("reset_err_cnt", 32'(bus.err_cnt), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc("r031", 1'b1, 15'h0010, 1'b1, 1'b0);
    chk("r031_out4", 32'(bus.out), 4);
    cyc("r032a", 1'b1, 15'h0000, 1'b1, 1'b0);
    chk("r032_zero", 32'(bus.out), 15);
    cyc("r032b", 1'b1, 15'h0006, 1'b1, 1'b0);
    chk("r032_multi", 32'({bus.out, bus.out_err}), 32'({4'd1, 1'b1}));
    cyc("r032c", 1'b0, 15'h0000, 1'b1, 1'b0);
    chk("r032_errcnt", 32'(bus.err_cnt), 1);
    cyc("r033a", 1'b1, 15'h0001, 1'b0, 1'b0);
    cyc("r033b", 1'b1, 15'h0020, 1'b0, 1'b0);
    chk("r033_full", 32'(bus.in_ready), 0);
    cyc("r033c", 1'b1, 15'h4000, 1'b0, 1'b0);
    cyc("r033d", 1'b1, 15'h4000, 1'b1, 1'b0);
    chk("r033_head5", 32'(bus.out), 5);
    cyc("r033e", 1'b1, 15'h4000, 1'b1, 1'b0);
    chk("r033_head14", 32'(bus.out), 14);
    cyc("r033f", 1'b0, 15'h0000, 1'b1, 1'b0);
    cyc("r034_fill", 1'b1, 15'h0001, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      cyc("r034", 1'b1, 15'(1 << (i % 15)), 1'b1, 1'b0);
      chk("r034_val", 32'(bus.out), 32'(i % 15));
    end
    cyc("r034_drain", 1'b0, 15'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 260; i++) cyc("r035", 1'b1, 15'h0003, 1'b1, 1'b0);
    chk("r035_sat", 32'(bus.err_cnt), 255);
    cyc("r035_clr", 1'b1, 15'h0003, 1'b1, 1'b1);
    chk("r035_cleared", 32'(bus.err_cnt), 0);
    cyc("r036_drain", 1'b0, 15'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cyc("r036_err", 1'b1, 15'h0300, 1'b1, 1'b0);
    cyc("r036_full", 1'b1, 15'h0002, 1'b0, 1'b0);
    chk("r036_pre_full", 32'(bus.in_ready), 0);
    chk("r036_pre_err", 32'(bus.err_cnt), 7);
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    err_m = 0;
    chk("r036_rst_out", 32'(bus.out), 0);
    chk("r036_rst_out_err", 32'(bus.out_err), 0);
    check_state("r036_rst");
    bus.in_valid = 1'b1;
    bus.in = 15'h0040;
    @(posedge clk);
    #1;
    check_state("r036_hold");
    rst = 1'b1;
    cyc("r036_fresh", 1'b1, 15'h0008, 1'b1, 1'b0);
    chk("r036_out3", 32'(bus.out), 3);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(3))
        0: d = 15'(1 << $urandom_range(14));
        1: d = '0;
        default: d = 15'($urandom);
      endcase
      cyc("rand", 1'($urandom), d, 1'($urandom_range(3) != 0), $urandom_range(31) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
